// File: rtl/ldpc_decode_ctrl.sv
// Min-sum LDPC decode sequencer: LLR load, check/variable phase alternation, per-iteration decision.
// Latency: start->init_en 1 cycle, last init_ack->chk_start 1, &var_done->decision_down 1, decision->done 1.
// Backpressure: each phase waits on node handshakes; a per-phase watchdog bounds every wait.
module ldpc_decode_ctrl #(
    parameter int N_VAR    = 8,
    parameter int N_CHK    = 4,
    parameter int MAX_ITER = 10,
    parameter int ITER_W   = 8,
    parameter int TIMEOUT  = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [N_VAR-1:0]  init_ack,
    input  logic [N_CHK-1:0]  chk_done,
    input  logic [N_VAR-1:0]  var_done,
    input  logic              syndrome_ok,
    output logic              init_en,
    output logic              chk_start,
    output logic              decision_down,
    output logic              decoder_down,
    output logic              busy,
    output logic              done,
    output logic              success,
    output logic              timeout_err,
    output logic [ITER_W-1:0] iter_cnt
);

    localparam int                WD_W      = $clog2(TIMEOUT + 1);
    localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(MAX_ITER - 1);
    localparam logic [ITER_W-1:0] ITER_MAX  = ITER_W'(MAX_ITER);
    localparam logic [WD_W-1:0]   WD_LAST   = WD_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CHK,
        VAR,
        DECIDE,
        FINISH
    } state_t;

    state_t            state;
    logic [N_VAR-1:0]  ack_mask;
    logic [N_VAR-1:0]  mask_nxt;
    logic [WD_W-1:0]   wd_cnt;
    logic              abort;
    logic              wd_hit;
    logic              last_iter;
    logic              term;

    assign mask_nxt  = ack_mask | init_ack;
    assign wd_hit    = (wd_cnt == WD_LAST);
    assign last_iter = (iter_cnt == ITER_LAST);
    assign term      = syndrome_ok | last_iter;

    // DECIDE is the only state that emits the decision handshake; a watchdog abort
    // reuses it so decision_down/decoder_down reach the nodes together.
    assign decision_down = (state == DECIDE);
    assign decoder_down  = decision_down & (abort | term);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ack_mask    <= '0;
            wd_cnt      <= '0;
            abort       <= 1'b0;
            init_en     <= 1'b0;
            chk_start   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            success     <= 1'b0;
            timeout_err <= 1'b0;
            iter_cnt    <= '0;
        end else begin
            chk_start <= 1'b0;
            done      <= 1'b0;
            wd_cnt    <= wd_cnt + 1'b1;
            case (state)
                IDLE: begin
                    wd_cnt <= '0;
                    if (start) begin
                        iter_cnt    <= '0;
                        success     <= 1'b0;
                        timeout_err <= 1'b0;
                        ack_mask    <= '0;
                        abort       <= 1'b0;
                        busy        <= 1'b1;
                        init_en     <= 1'b1;
                        state       <= LOAD;
                    end
                end
                LOAD: begin
                    ack_mask <= mask_nxt;
                    if (&mask_nxt) begin
                        init_en   <= 1'b0;
                        chk_start <= 1'b1;
                        wd_cnt    <= '0;
                        state     <= CHK;
                    end else if (wd_hit) begin
                        init_en     <= 1'b0;
                        abort       <= 1'b1;
                        timeout_err <= 1'b1;
                        state       <= DECIDE;
                    end
                end
                CHK: begin
                    if (&chk_done) begin
                        wd_cnt <= '0;
                        state  <= VAR;
                    end else if (wd_hit) begin
                        abort       <= 1'b1;
                        timeout_err <= 1'b1;
                        state       <= DECIDE;
                    end
                end
                VAR: begin
                    if (&var_done) begin
                        state <= DECIDE;
                    end else if (wd_hit) begin
                        abort       <= 1'b1;
                        timeout_err <= 1'b1;
                        state       <= DECIDE;
                    end
                end
                DECIDE: begin
                    wd_cnt <= '0;
                    if (abort) begin
                        success <= 1'b0;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state   <= FINISH;
                    end else begin
                        if (iter_cnt != ITER_MAX) begin
                            iter_cnt <= iter_cnt + 1'b1;
                        end
                        if (term) begin
                            success <= syndrome_ok;
                            done    <= 1'b1;
                            busy    <= 1'b0;
                            state   <= FINISH;
                        end else begin
                            chk_start <= 1'b1;
                            state     <= CHK;
                        end
                    end
                end
                FINISH: begin
                    wd_cnt <= '0;
                    abort  <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    wd_cnt <= '0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/ldpc_decode_ctrl.md
# ldpc_decode_ctrl

Top-level sequencer for the min-sum LDPC decoder. It loads channel LLRs into every variable node and alternates check-node and variable-node update phases. After each iteration it issues the per-iteration decision handshake. It stops on a zero syndrome, at the iteration limit, or on a phase watchdog timeout.

## Interface
- `N_VAR`, 8: number of variable nodes controlled.
- `N_CHK`, 4: number of check nodes controlled.
- `MAX_ITER`, 10: maximum decoding iterations; must be ≥1.
- `ITER_W`, 8: width of iteration counter; must satisfy `2^ITER_W > MAX_ITER`.
- `TIMEOUT`, 1023: watchdog cycle limit per wait phase.
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request to begin a codeword; ignored unless `busy`=0.
- `init_ack`  in  `N_VAR`  per-variable-node "initial value taken" pulses.
- `chk_done`  in  `N_CHK`  per-check-node update-valid levels.
- `var_done`  in  `N_VAR`  per-variable-node update-complete levels; held until `decision_down`.
- `syndrome_ok`  in  1  all parity checks satisfied for current hard decisions; valid while all `var_done` are high.
- `init_en`  out  1  initial-value-enable broadcast to all variable nodes.
- `chk_start`  out  1  one-cycle pulse launching a check-node update phase.
- `decision_down`  out  1  one-cycle pulse ending an iteration.
- `decoder_down`  out  1  asserted with `decision_down` when decoding terminates.
- `busy`  out  1  high from accepted `start` until `done`.
- `done`  out  1  one-cycle completion pulse.
- `success`  out  1  syndrome satisfied at termination; held until next accepted `start`.
- `timeout_err`  out  1  watchdog fired; held until next accepted `start`.
- `iter_cnt`  out  `ITER_W`  completed iterations; held after `done`.

## Operation
- States: IDLE, LOAD, CHK, VAR, DECIDE, FINISH.
- IDLE:
  - On `start`, clear `iter_cnt`, `success`, `timeout_err` and the ack mask.
  - Set `busy`=1 and go to LOAD.
- LOAD:
  - Drive `init_en`=1.
  - OR `init_ack` into a sticky `N_VAR`-bit mask each cycle.
  - When the mask, including the current cycle's acks, is all ones: drop `init_en`, pulse `chk_start`, go to CHK.
- CHK: wait for `&chk_done`, then go to VAR.
- VAR: wait for `&var_done`, then go to DECIDE.
- DECIDE takes exactly one cycle:
  - Pulse `decision_down`.
  - `term` = `syndrome_ok` OR (`iter_cnt`+1 == `MAX_ITER`).
  - `decoder_down` = `term`; `iter_cnt` increments.
  - If `term`: `success` = `syndrome_ok`, go to FINISH.
  - Otherwise: pulse `chk_start` in the following cycle and go to CHK.
- FINISH: pulse `done`, clear `busy`, go to IDLE.
- Watchdog:
  - A cycle counter clears on every state change.
  - If LOAD, CHK or VAR stays resident for `TIMEOUT` cycles: set `timeout_err`, pulse `decision_down` and `decoder_down` together (forces node reset to INITIAL), go to FINISH with `success`=0.
- Arithmetic: `iter_cnt` saturates at `MAX_ITER` and never wraps. The watchdog counter is ceil(log2(`TIMEOUT`+1)) bits.

## Timing
- Reset values:
  - all outputs 0, `iter_cnt`=0, state IDLE, mask 0;
  - the counter clears in the same edge as `rst`.
- `rst` mid-decode aborts immediately. No `done` pulse is produced, and the next cycle is IDLE.
- `start` → `init_en` high on the next cycle, with `busy` high on the same cycle.
- Acks arriving in any order or simultaneously are all captured. If the last ack arrives on cycle t, `init_en` is low and `chk_start` high at t+1.
- `&var_done` sampled high on cycle t → `decision_down` at t+1 (DECIDE).
- `chk_start` for the next iteration comes at t+2.
- Minimum iteration length is 3 cycles (CHK, VAR, DECIDE) plus the node latencies.
- `done` is asserted exactly one cycle after the terminating `decision_down`.
- `start` while `busy` is ignored with no side effects. `start` in the same cycle as `done` is also ignored.
- `syndrome_ok` is sampled only in DECIDE.
- If the watchdog and phase completion fire in the same cycle, completion wins.

## Test plan
- Single codeword, `syndrome_ok`=1 at first decision (N_VAR=8):
  - `decision_down` and `decoder_down` pulse together;
  - `done` one cycle later;
  - `success`=1, `iter_cnt`=1.
- `syndrome_ok` held 0, MAX_ITER=10:
  - exactly 10 `decision_down` pulses; only the 10th carries `decoder_down`;
  - 10 `chk_start` pulses;
  - `success`=0, `iter_cnt`=10.
- Out-of-order `init_ack`: bits 0–3 at cycle 2, bits 7,5 at 4, bits 4,6 at 9 → `init_en` falls and `chk_start` pulses at cycle 10.
- One `chk_done` bit stuck low, TIMEOUT=15:
  - `timeout_err`=1 and `decoder_down` pulse after 15 cycles in CHK;
  - `done` follows; `success`=0.
- `rst` asserted during VAR of iteration 3:
  - next cycle all outputs 0, `busy`=0, no `done`;
  - a fresh `start` decodes normally.
- `start` pulsed during LOAD and on the `done` cycle → ignored; `iter_cnt` and `success` unchanged.
